mips_div_unit: RTL and testbench

//   Multi-cycle restoring divider for the MIPS DIV/DIVU instructions: subtraction-based

---
 rtl/mips_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mips_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle through a single WIDTH-bit subtractor.
// Quotient goes to LO, remainder to HI, both held until the next done.
//
// Handshake: start is sampled only on an edge where busy=0, and is
// ignored while busy=1. done is a one-cycle pulse. On that pulse and
// afterwards, quotient/remainder/div_by_zero hold the last result.
// busy is already low in the done cycle, so a new start can be issued
// in the done cycle itself (back-to-back operation).
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // Shift/subtract step of one iteration.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             accept;

  // Magnitude of a value when it is treated as signed; raw otherwise.
  // The most negative value maps to itself, which still reads correctly
  // as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Restoring step: the bit shifted out of rem is kept in shifted[WIDTH],
  // so divisors above 2^(WIDTH-1) still divide correctly. If that bit is
  // set, the shifted value exceeds any divisor. When the subtraction is
  // accepted the true difference fits WIDTH bits, so modulo-2^WIDTH is exact.
  always_comb begin
    shifted          = {rem_q, dvd_q[WIDTH-1]};
    {borrow, diff}   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dsr_q};
    accept           = shifted[WIDTH] | ~borrow;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed & dividend[WIDTH-1];
          rem_d     = '0;
          dsr_d     = magnitude(divisor, is_signed);
          cnt_d     = CNT_INIT;
          if (divisor == '0) begin
            // Zero path reports the raw dividend as the remainder.
            dvd_d   = dividend;
            state_d = S_ZERO;
          end else begin
            dvd_d   = magnitude(dividend, is_signed);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d = accept ? diff : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], accept};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        quo_out_d = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_out_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d     = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      S_ZERO: begin
        quo_out_d = '1;
        rem_out_d = dvd_q;
        dbz_d     = 1'b1;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    quotient    = quo_out_q;
    remainder   = rem_out_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed checks of mips_div_unit (WIDTH=32).
module tb_mips_div_unit;

  localparam int W = 32;
  localparam int MAX_WAIT = 100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int errors;

  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  mips_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present an op for one edge (E0). Called 1ns after a rising
  // edge; returns 1ns after E0.
  task automatic drive_start(input logic s, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // Driver: count edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith;
    vec_t v[$];
    int   n;
    v.push_back('{"divu_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33});
    v.push_back('{"div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33});
    v.push_back('{"div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33});
    v.push_back('{"div_min_m1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33});
    v.push_back('{"divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33});
    v.push_back('{"divu_big_dsr",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0, 33});
    v.push_back('{"divu_hi_dsr",   1'b0, 32'h8000_0001,  32'h8000_0000,  32'd1,          32'd1,          1'b0, 33});
    v.push_back('{"div_m100_m7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33});
    v.push_back('{"divu_small_big",1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33});
    v.push_back('{"divu_5_0",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1});
    v.push_back('{"divu_9_3",      1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33});
    v.push_back('{"div_m8_0",      1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  1'b1, 1});
    v.push_back('{"divu_unsgn_neg",1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 33});
    foreach (v[i]) begin
      drive_start(v[i].s, v[i].a, v[i].b);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", v[i].name, busy); end
      wait_done(n);
      checks++;
      if (n != v[i].lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", v[i].name, n, v[i].lat); end
      checks++;
      if (quotient !== v[i].q) begin errors++; $display("FAIL %s_quotient got=%h exp=%h", v[i].name, quotient, v[i].q); end
      checks++;
      if (remainder !== v[i].r) begin errors++; $display("FAIL %s_remainder got=%h exp=%h", v[i].name, remainder, v[i].r); end
      checks++;
      if (div_by_zero !== v[i].z) begin errors++; $display("FAIL %s_dbz got=%b exp=%b", v[i].name, div_by_zero, v[i].z); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done got=%b exp=0", v[i].name, busy); end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", v[i].name, done); end
    end
  endtask

  task automatic test_ignore_start;
    int n;
    drive_start(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    // Second request lands on E10 while busy.
    drive_start(1'b1, 32'd50, 32'd5);
    wait_done(n);
    checks++; if (n != 23) begin errors++; $display("FAIL ignore_latency got=%0d exp=23", n); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL ignore_quotient got=%h exp=%h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL ignore_remainder got=%h exp=%h", remainder, 32'd2); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    drive_start(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL midrst_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL midrst_remainder got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    drive_start(1'b0, 32'd1000, 32'd10);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL midrst_latency got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd100) begin errors++; $display("FAIL midrst_quotient2 got=%h exp=%h", quotient, 32'd100); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL midrst_remainder2 got=%h exp=0", remainder); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n;
    drive_start(1'b0, 32'd20, 32'd3);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd6) begin errors++; $display("FAIL b2b_q1 got=%h exp=%h", quotient, 32'd6); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_r1 got=%h exp=%h", remainder, 32'd2); end
    // New op issued in the done cycle.
    drive_start(1'b1, 32'd21, 32'hFFFF_FFFC);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got=%b exp=0", done); end
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=33", n); end
    checks++; if (quotient !== 32'hFFFF_FFFB) begin errors++; $display("FAIL b2b_q2 got=%h exp=%h", quotient, 32'hFFFF_FFFB); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL b2b_r2 got=%h exp=%h", remainder, 32'd1); end
    @(posedge clk);
    #1;
  endtask

  // Sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
